votador_seq: RTL and testbench
==============================

Name: votador_seq

Overview:
Sequential majority voter that accepts a ballot of N single-bit votes serially, one per accepted handshake.
- Declares the majority result once the ballot closes.
- Holds the result until the consumer acknowledges it.
- Serial-input counterpart of the team's combinational three-input voter; used where voters share one line instead of one wire each.

Parameters:
N, 3, number of votes per ballot; must be odd and >= 1 (elaboration error otherwise)
W, $clog2(N+1), width of the vote counters (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
voto_valid  input  1  a vote is presented on voto this cycle
voto  input  1  vote value: 1 = yes, 0 = no
voto_ready  output  1  block accepts a vote this cycle
resultado  output  1  majority result: 1 if yes votes > N/2
resultado_valid  output  1  resultado is valid and held
resultado_ack  input  1  consumer takes the result; block starts a new ballot
n_si  output  W  running count of yes votes in the current ballot
n_votos  output  W  running count of votes accepted in the current ballot

Behaviour:
- Reset (async assert, sync release):
  - state = RECOGE
  - voto_ready = 1, resultado = 0, resultado_valid = 0
  - n_si = 0, n_votos = 0
- States:
  - RECOGE: voto_ready = 1. A vote is accepted on a rising edge where voto_valid & voto_ready.
    - Acceptance increments n_votos; increments n_si when voto = 1.
    - When the accepted vote makes n_votos == N: on that same edge go to FIN, register resultado = (n_si_next > N/2), set resultado_valid = 1.
  - FIN: voto_ready = 0; voto_valid is ignored and no count changes. resultado, resultado_valid, n_si and n_votos are held.
    - On resultado_ack = 1: clear counters and resultado_valid, resultado = 0, return to RECOGE.
    - voto_ready rises the cycle after the ack edge.
- Latency: resultado_valid asserts the cycle after the edge accepting the last vote.
- Throughput: one vote per cycle. One idle cycle per ballot (FIN → RECOGE).
- resultado_ack while in RECOGE: ignored.
- voto_valid low: no count change; gaps between votes are allowed.
- N = 1: the single vote is the result.
- Counters never exceed N; no wrap-around.
- Reset mid-ballot: partial ballot discarded; all outputs return to reset values immediately.

Optional Feature:
Macro VOTADOR_SEQ_QUORUM_EN.
- Defined (early decision): the ballot closes as soon as either count exceeds N/2, i.e. n_si_next > N/2 or (n_votos_next - n_si_next) > N/2. Go to FIN with the corresponding resultado. Remaining votes are not requested; n_votos reflects only accepted votes.
- Undefined: the ballot always collects all N votes.
- Either way, resultado is the same for any vote sequence; only latency and n_votos differ.

Decomposition:
Package votador_pkg holds:
- State encoding constants RECOGE, FIN.
- Counter width function for N.

One sub-module, contador_votos:
- Width-W counter with enable and synchronous clear.
- Instantiated twice: n_si and n_votos.
- FSM and compare logic stay in votador_seq.

Test Plan:
- Reset: N=3; hold reset_n = 0 with voto_valid = 1 → voto_ready = 1, resultado_valid = 0, counters 0; no counting until release.
- Majority yes, with gaps: N=3; votes 1,0,1 with voto_valid gaps between them → resultado_valid = 1 one cycle after third accept; resultado = 1; n_si = 2; n_votos = 3.
- Hold until ack: N=3; votes 0,0,1; keep voto_valid = 1 five more cycles with no ack → resultado = 0 held, voto_ready = 0, counts frozen at 1/3.
- Ack and back-to-back ballots: after the hold case, pulse resultado_ack → counters 0, resultado_valid = 0 next cycle, voto_ready = 1. Then N=5, votes 1,1,0,1,0 → resultado = 1, n_si = 3.
- Reset mid-ballot: N=5; after two accepted votes assert reset_n = 0 → counters 0 immediately; the next full ballot of five 0s gives resultado = 0.
- QUORUM_EN defined: N=5; votes 1,1,1 → resultado_valid one cycle after the third accept, n_votos = 3, voto_ready = 0. Same stimulus undefined → waits for five votes.

Source files
------------

// File: rtl/votador_pkg.sv
// Shared types and helpers for the serial majority voter.
package votador_pkg;

   typedef enum logic {
      RECOGE = 1'b0,
      FIN    = 1'b1
   } estado_t;

   // Bits needed to count from 0 up to n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/contador_votos.sv
// Width-W up counter with enable and synchronous clear; clear wins over enable.
module contador_votos #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/votador_seq.sv
// Serial majority voter: collects N one-bit votes, holds the result until acked.
// Define VOTADOR_SEQ_QUORUM_EN to close the ballot as soon as one side has a majority.
module votador_seq
   import votador_pkg::*;
#(
   parameter  int unsigned N = 3,
   localparam int unsigned W = cnt_width(N)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         voto_valid,
   input  logic         voto,
   output logic         voto_ready,
   output logic         resultado,
   output logic         resultado_valid,
   input  logic         resultado_ack,
   output logic [W-1:0] n_si,
   output logic [W-1:0] n_votos
);

   if ((N % 2) != 1) begin : g_n_invalid
      $error("votador_seq: N must be odd and >= 1");
   end

   estado_t      state_q, state_d;
   logic         resultado_q, resultado_d;
   logic         valid_q, valid_d;
   logic         ready_q, ready_d;
   logic         accept, cierra, clr;
   logic [W-1:0] n_si_next, n_votos_next;

   // Counts as they will be after this edge, used for the closing decision.
   always_comb begin
      accept       = (state_q == RECOGE) && voto_valid;
      n_votos_next = n_votos + W'(accept);
      n_si_next    = n_si + W'(accept && voto);
   end

`ifdef VOTADOR_SEQ_QUORUM_EN
   logic [W-1:0] n_no_next;
   always_comb begin
      n_no_next = n_votos_next - n_si_next;
      cierra    = accept && ((n_votos_next == W'(N)) ||
                             (n_si_next > W'(N / 2)) ||
                             (n_no_next > W'(N / 2)));
   end
`else
   always_comb begin
      cierra = accept && (n_votos_next == W'(N));
   end
`endif

   always_comb begin
      state_d     = state_q;
      resultado_d = resultado_q;
      valid_d     = valid_q;
      ready_d     = ready_q;
      clr         = 1'b0;
      case (state_q)
         RECOGE: begin
            if (cierra) begin
               state_d     = FIN;
               resultado_d = (n_si_next > W'(N / 2));
               valid_d     = 1'b1;
               ready_d     = 1'b0;
            end
         end
         FIN: begin
            if (resultado_ack) begin
               state_d     = RECOGE;
               resultado_d = 1'b0;
               valid_d     = 1'b0;
               ready_d     = 1'b1;
               clr         = 1'b1;
            end
         end
         default: begin
            state_d = RECOGE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RECOGE;
         resultado_q <= 1'b0;
         valid_q     <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         resultado_q <= resultado_d;
         valid_q     <= valid_d;
         ready_q     <= ready_d;
      end
   end

   contador_votos #(.W(W)) u_cnt_si (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .en      (accept && voto),
      .cnt     (n_si)
   );

   contador_votos #(.W(W)) u_cnt_votos (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .en      (accept),
      .cnt     (n_votos)
   );

   assign voto_ready      = ready_q;
   assign resultado       = resultado_q;
   assign resultado_valid = valid_q;

endmodule

// File: tb/tb_votador_seq.sv
// Scoreboard bench for votador_seq with one N=3 and one N=5 instance.
// Follows VOTADOR_SEQ_QUORUM_EN the same way the design does.
module tb_votador_seq;

`ifdef VOTADOR_SEQ_QUORUM_EN
   localparam bit QUORUM = 1'b1;
`else
   localparam bit QUORUM = 1'b0;
`endif

   typedef struct {
      logic res;
      int   si;
      int   nv;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       v3_valid, v3, ack3, ready3, res3, rv3;
   logic [1:0] si3, nv3;
   logic       v5_valid, v5, ack5, ready5, res5, rv5;
   logic [2:0] si5, nv5;

   exp_t q3[$];
   exp_t q5[$];
   exp_t e3, e5;
   logic seen3 = 1'b0;
   logic seen5 = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   votador_seq #(.N(3)) u_dut3 (
      .clk             (clk),
      .reset_n         (reset_n),
      .voto_valid      (v3_valid),
      .voto            (v3),
      .voto_ready      (ready3),
      .resultado       (res3),
      .resultado_valid (rv3),
      .resultado_ack   (ack3),
      .n_si            (si3),
      .n_votos         (nv3)
   );

   votador_seq #(.N(5)) u_dut5 (
      .clk             (clk),
      .reset_n         (reset_n),
      .voto_valid      (v5_valid),
      .voto            (v5),
      .voto_ready      (ready5),
      .resultado       (res5),
      .resultado_valid (rv5),
      .resultado_ack   (ack5),
      .n_si            (si5),
      .n_votos         (nv5)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int get_ready(input bit s5);
      return s5 ? int'(ready5) : int'(ready3);
   endfunction
   function automatic int get_rv(input bit s5);
      return s5 ? int'(rv5) : int'(rv3);
   endfunction
   function automatic int get_res(input bit s5);
      return s5 ? int'(res5) : int'(res3);
   endfunction
   function automatic int get_si(input bit s5);
      return s5 ? int'(si5) : int'(si3);
   endfunction
   function automatic int get_nv(input bit s5);
      return s5 ? int'(nv5) : int'(nv3);
   endfunction

   task automatic set_vote(input bit s5, input logic val, input logic v);
      if (s5) begin
         v5_valid = val;
         v5       = v;
      end else begin
         v3_valid = val;
         v3       = v;
      end
   endtask

   task automatic set_ack(input bit s5, input logic a);
      if (s5) ack5 = a;
      else    ack3 = a;
   endtask

   // Reference voter; votes[i] is the i-th vote cast.
   function automatic exp_t model(input int n, input logic [7:0] votes);
      exp_t e;
      e.si = 0;
      e.nv = 0;
      for (int i = 0; i < n; i++) begin
         e.nv++;
         if (votes[i]) e.si++;
         if (QUORUM && ((e.si > n / 2) || ((e.nv - e.si) > n / 2))) break;
      end
      e.res = (e.si > n / 2);
      return e;
   endfunction

   // Enters and leaves on a falling edge; the vote is accepted on the rising edge in between.
   task automatic send_vote(input bit s5, input logic v, input int gap);
      int guard;
      repeat (gap) @(negedge clk);
      set_vote(s5, 1'b1, v);
      guard = 0;
      while (get_ready(s5) == 0 && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 16) chk("ready_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      set_vote(s5, 1'b0, 1'b0);
   endtask

   task automatic run_ballot(input bit s5, input logic [7:0] votes, input int gap,
                             input bit ack_mid, output exp_t e);
      e = model(s5 ? 5 : 3, votes);
      if (s5) q5.push_back(e);
      else    q3.push_back(e);
      for (int i = 0; i < e.nv; i++) begin
         send_vote(s5, votes[i], (i == 0) ? 0 : gap);
         if (ack_mid && i == 0) begin
            set_ack(s5, 1'b1);
            @(negedge clk);
            set_ack(s5, 1'b0);
            chk("ack_in_recoge_nv", get_nv(s5), 1);
            chk("ack_in_recoge_ready", get_ready(s5), 1);
         end
      end
      chk("latency_valid", get_rv(s5), 1);
      chk("fin_ready", get_ready(s5), 0);
   endtask

   task automatic pulse_ack(input bit s5);
      set_ack(s5, 1'b1);
      @(negedge clk);
      set_ack(s5, 1'b0);
      chk("ack_valid", get_rv(s5), 0);
      chk("ack_res", get_res(s5), 0);
      chk("ack_ready", get_ready(s5), 1);
      chk("ack_si", get_si(s5), 0);
      chk("ack_nv", get_nv(s5), 0);
   endtask

   // Scoreboard: compare on the first cycle each result is presented.
   always @(negedge clk) begin
      if (rv3 && !seen3) begin
         if (q3.size() == 0) begin
            chk("sb3_unexpected", 1, 0);
         end else begin
            e3 = q3.pop_front();
            chk("sb3_res", int'(res3), int'(e3.res));
            chk("sb3_si", int'(si3), e3.si);
            chk("sb3_nv", int'(nv3), e3.nv);
         end
      end
      if (rv5 && !seen5) begin
         if (q5.size() == 0) begin
            chk("sb5_unexpected", 1, 0);
         end else begin
            e5 = q5.pop_front();
            chk("sb5_res", int'(res5), int'(e5.res));
            chk("sb5_si", int'(si5), e5.si);
            chk("sb5_nv", int'(nv5), e5.nv);
         end
      end
      seen3 = rv3;
      seen5 = rv5;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired got=%0d exp=%0d", 1, 0);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      reset_n = 1'b0;
      set_vote(1'b0, 1'b1, 1'b1);
      set_vote(1'b1, 1'b1, 1'b1);
      ack3 = 1'b0;
      ack5 = 1'b0;

      // Reset held with votes presented
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("rst_ready", get_ready(s != 0), 1);
         chk("rst_valid", get_rv(s != 0), 0);
         chk("rst_res", get_res(s != 0), 0);
         chk("rst_si", get_si(s != 0), 0);
         chk("rst_nv", get_nv(s != 0), 0);
      end
      set_vote(1'b0, 1'b0, 1'b0);
      set_vote(1'b1, 1'b0, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_nv3", get_nv(1'b0), 0);

      // N=3: votes 1,0,1 with gaps and an ignored ack mid-ballot
      run_ballot(1'b0, 8'b0000_0101, 2, 1'b1, e);
      chk("maj_res3", get_res(1'b0), 1);
      pulse_ack(1'b0);

      // N=3: votes 0,0,1 then hold five cycles with votes still offered
      run_ballot(1'b0, 8'b0000_0100, 0, 1'b0, e);
      set_vote(1'b0, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      chk("hold_valid", get_rv(1'b0), 1);
      chk("hold_res", get_res(1'b0), int'(e.res));
      chk("hold_ready", get_ready(1'b0), 0);
      chk("hold_si", get_si(1'b0), e.si);
      chk("hold_nv", get_nv(1'b0), e.nv);
      set_vote(1'b0, 1'b0, 1'b0);
      pulse_ack(1'b0);

      // N=5: votes 1,1,0,1,0
      run_ballot(1'b1, 8'b0000_1011, 1, 1'b0, e);
      chk("maj_res5", get_res(1'b1), 1);
      pulse_ack(1'b1);

      // N=5: reset after two accepted votes, then five 0s
      send_vote(1'b1, 1'b1, 0);
      send_vote(1'b1, 1'b0, 0);
      chk("mid_nv_before", get_nv(1'b1), 2);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_nv", get_nv(1'b1), 0);
      chk("mid_rst_si", get_si(1'b1), 0);
      chk("mid_rst_ready", get_ready(1'b1), 1);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_ballot(1'b1, 8'b0000_0000, 0, 1'b0, e);
      chk("zeros_res5", get_res(1'b1), 0);
      pulse_ack(1'b1);

      // N=5: three yes votes; early close only with the quorum option
      q5.push_back(model(5, 8'b0000_0111));
      for (int i = 0; i < 3; i++) send_vote(1'b1, 1'b1, 0);
      chk("q_nv", get_nv(1'b1), 3);
`ifdef VOTADOR_SEQ_QUORUM_EN
      chk("q_valid", get_rv(1'b1), 1);
      chk("q_ready", get_ready(1'b1), 0);
      chk("q_res", get_res(1'b1), 1);
`else
      chk("q_valid", get_rv(1'b1), 0);
      chk("q_ready", get_ready(1'b1), 1);
      send_vote(1'b1, 1'b0, 0);
      send_vote(1'b1, 1'b0, 0);
      chk("full_valid", get_rv(1'b1), 1);
      chk("full_nv", get_nv(1'b1), 5);
      chk("full_res", get_res(1'b1), 1);
`endif
      pulse_ack(1'b1);

      repeat (2) @(negedge clk);
      chk("sb3_drained", q3.size(), 0);
      chk("sb5_drained", q5.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
